issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Issue-stage hazard controller for the vectorial ASIP pipeline. Sits between the instruction decoder and the execute stage and decides, cycle by cycle, whether the decoded instruction may issue or must stall. Tracks in-flight register writes with per-register latency countdowns, and tracks occupancy of the single data-memory write port. Sequences scalar (short) and vector (multi-cycle) operations sharing one register file and one memory port.

## Interface
- SCALAR_LAT, 2: cycles from issue until a scalar result is written back.
- VECTOR_LAT, 5: cycles from issue until a vector result or vector store completes.
- CNT_W, 3: counter width; both latencies must be in 1..2^CNT_W-1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  decoded instruction present this cycle.
- id_rd  in  4  destination register (decoder RegToWrite).
- id_rs1, id_rs2  in  4 each  source registers.
- id_use_rs1, id_use_rs2  in  1 each  source actually read.
- id_reg_write_en  in  1  instruction writes id_rd (decoder RegWriteEn).
- id_mem_write  in  1  instruction writes data memory (decoder MemoryWrite).
- id_is_vector  in  1  selects VECTOR_LAT, else SCALAR_LAT.
- flush  in  1  squash the current decoded instruction.
- id_issue  out  1  instruction accepted this cycle.
- id_stall  out  1  instruction held; decoder must keep inputs stable.
- busy_mask  out  16  bit r set while cnt[r] != 0.
- mem_busy  out  1  memory write port occupied.

## Operation
- State: cnt[0..15] (CNT_W bits each), mem_cnt (CNT_W bits). Reset: all zero; id_issue=0 and id_stall=0 while id_valid=0; busy_mask=0; mem_busy=0.
- lat = id_is_vector ? VECTOR_LAT : SCALAR_LAT.
- pend(r) = cnt[r] != 0 (see Configuration for forwarding relaxation).
- hazard = (id_use_rs1 & pend(id_rs1)) | (id_use_rs2 & pend(id_rs2)) | (id_reg_write_en & cnt[id_rd] != 0) | (id_mem_write & mem_cnt != 0).
- WAW check (rd) and memory-port check are always strict; never relaxed.
- id_issue = id_valid & ~hazard & ~flush; id_stall = id_valid & hazard & ~flush. Both combinational; never high together.
- Each rising edge: every nonzero counter decrements by 1, saturating at 0.
- On id_issue & id_reg_write_en: cnt[id_rd] <= lat (load overrides decrement of that entry).
- On id_issue & id_mem_write: mem_cnt <= lat.
- An instruction with both write enables loads both.
- flush: current instruction neither issues nor stalls; in-flight counters keep counting (already-issued work completes).
- rst_n low at any time: all counters clear immediately, independent of clk.

## Timing
- Zero-cycle decision: issue/stall resolved in the same cycle id_valid is seen.
- Producer issued in cycle T with latency L: cnt = L during T+1, reaching 0 in cycle T+L+1.
- Dependent reader earliest issue: T+L+1 (T+L with FORWARD_EN).
- Same-rd writer earliest issue: T+L+1 always.
- Second memory write earliest issue: T+L+1.
- Stall holds until hazard clears; no timeout, no priority inversion (single requester).

## Configuration
- ISSUE_FORWARD_EN defined: pend(r) = cnt[r] > 1; a reader may issue in the final cycle of its producer, relying on the writeback-to-execute bypass.
- Undefined: pend(r) = cnt[r] != 0; no bypass assumed, one extra stall cycle per RAW dependency.

## Test plan
- Reset: hold rst_n=0, drive id_valid=1 -> busy_mask=0, mem_busy=0, id_issue=1; release, one cycle later busy_mask=0.
- RAW vector: cycle 0 issue vector write R3; cycle 1 present read of R3 -> id_stall cycles 1-5, id_issue cycle 6 (cycle 5 with ISSUE_FORWARD_EN).
- Independent: after vector write R3, reader of R4/R5 in cycle 1 -> id_issue=1 immediately, busy_mask=16'h0008.
- WAW scalar: cycle 0 scalar write R7, cycle 1 scalar write R7 -> stall cycles 1-2, issue cycle 3, same under both macro settings.
- Memory port: vector store cycle 0, vector store cycle 1 -> mem_busy cycles 1-5, second issues cycle 6; flush in cycle 3 -> id_stall=0, id_issue=0, mem_busy still 1.
- Mid-op reset: cnt[3]=4, pull rst_n low between edges -> busy_mask=0 immediately; after release a read of R3 issues at once.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller: per-register latency countdowns plus memory write-port occupancy.
// Optional macro ISSUE_FORWARD_EN lets a reader issue in its producer's final cycle.
module issue_scoreboard #(
   parameter int unsigned SCALAR_LAT = 2,
   parameter int unsigned VECTOR_LAT = 5,
   parameter int unsigned CNT_W      = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [3:0]  id_rd,
   input  logic [3:0]  id_rs1,
   input  logic [3:0]  id_rs2,
   input  logic        id_use_rs1,
   input  logic        id_use_rs2,
   input  logic        id_reg_write_en,
   input  logic        id_mem_write,
   input  logic        id_is_vector,
   input  logic        flush,
   output logic        id_issue,
   output logic        id_stall,
   output logic [15:0] busy_mask,
   output logic        mem_busy
);

   localparam int unsigned NREG = 16;
   localparam int unsigned RW   = 4;

   logic [CNT_W-1:0] cnt [NREG];
   logic [CNT_W-1:0] mem_cnt;
   logic [CNT_W-1:0] lat;
   logic             pend_rs1;
   logic             pend_rs2;
   logic             waw;
   logic             mem_hz;
   logic             hazard;

   assign lat = id_is_vector ? CNT_W'(VECTOR_LAT) : CNT_W'(SCALAR_LAT);

   // RAW pending test; the bypass lets a reader overlap the producer's last cycle
   always_comb begin
      pend_rs1 = 1'b0;
      pend_rs2 = 1'b0;
`ifdef ISSUE_FORWARD_EN
      pend_rs1 = cnt[id_rs1] > CNT_W'(1);
      pend_rs2 = cnt[id_rs2] > CNT_W'(1);
`else
      pend_rs1 = cnt[id_rs1] != '0;
      pend_rs2 = cnt[id_rs2] != '0;
`endif
   end

   // WAW and memory-port checks stay strict regardless of forwarding
   assign waw    = id_reg_write_en & (cnt[id_rd] != '0);
   assign mem_hz = id_mem_write & (mem_cnt != '0);
   assign hazard = (id_use_rs1 & pend_rs1) | (id_use_rs2 & pend_rs2) | waw | mem_hz;

   assign id_issue = id_valid & ~hazard & ~flush;
   assign id_stall = id_valid &  hazard & ~flush;

   always_comb begin
      busy_mask = '0;
      for (int r = 0; r < NREG; r++) busy_mask[r] = cnt[r] != '0;
   end

   assign mem_busy = mem_cnt != '0;

   // Register countdowns: a fresh load on issue overrides the decrement
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            if (id_issue && id_reg_write_en && (id_rd == RW'(r)))
               cnt[r] <= lat;
            else if (cnt[r] != '0)
               cnt[r] <= cnt[r] - CNT_W'(1);
         end
      end
   end

   // Memory write-port occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mem_cnt <= '0;
      else if (id_issue && id_mem_write)
         mem_cnt <= lat;
      else if (mem_cnt != '0)
         mem_cnt <= mem_cnt - CNT_W'(1);
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: RAW, WAW, independent reads, memory port, flush, async reset.
module tb_issue_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [3:0]  id_rd;
   logic [3:0]  id_rs1;
   logic [3:0]  id_rs2;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic        id_reg_write_en;
   logic        id_mem_write;
   logic        id_is_vector;
   logic        flush;
   logic        id_issue;
   logic        id_stall;
   logic [15:0] busy_mask;
   logic        mem_busy;

   int total = 0;
   int bad   = 0;

   issue_scoreboard dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_valid        (id_valid),
      .id_rd           (id_rd),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .id_reg_write_en (id_reg_write_en),
      .id_mem_write    (id_mem_write),
      .id_is_vector    (id_is_vector),
      .flush           (flush),
      .id_issue        (id_issue),
      .id_stall        (id_stall),
      .busy_mask       (busy_mask),
      .mem_busy        (mem_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write_en = 0;
      id_mem_write = 0; id_is_vector = 0; flush = 0;
   endtask

   task automatic wr(input logic vec, input logic [3:0] rd);
      clr();
      id_valid = 1; id_is_vector = vec; id_rd = rd; id_reg_write_en = 1;
   endtask

   task automatic rd2(input logic [3:0] a, input logic [3:0] b);
      clr();
      id_valid = 1; id_rs1 = a; id_rs2 = b; id_use_rs1 = 1; id_use_rs2 = 1;
   endtask

   task automatic idle(input int n);
      clr();
      for (int i = 0; i < n; i++) cyc();
   endtask

   int first_raw;

   initial begin
`ifdef ISSUE_FORWARD_EN
      first_raw = 5;
`else
      first_raw = 6;
`endif
      // reset held: issue allowed, nothing busy
      clr();
      rst_n = 0;
      id_valid = 1;
      #3;
      chk("rst_busy", 32'(busy_mask), 32'h0);
      chk("rst_mem", 32'(mem_busy), 32'h0);
      chk("rst_issue", 32'(id_issue), 32'h1);
      chk("rst_stall", 32'(id_stall), 32'h0);
      #4;
      rst_n = 1;
      id_valid = 0;
      cyc();
      chk("post_rst_busy", 32'(busy_mask), 32'h0);
      chk("idle_issue", 32'(id_issue), 32'h0);
      chk("idle_stall", 32'(id_stall), 32'h0);

      // RAW on vector producer R3
      wr(1, 4'd3);
      #2 chk("raw_prod_issue", 32'(id_issue), 32'h1);
      cyc();
      rd2(4'd3, 4'd0);
      id_use_rs2 = 0;
      for (int c = 1; c <= first_raw; c++) begin
         #2;
         chk($sformatf("raw_issue_c%0d", c), 32'(id_issue), 32'(c == first_raw));
         chk($sformatf("raw_stall_c%0d", c), 32'(id_stall), 32'(c != first_raw));
         chk($sformatf("raw_busy_c%0d", c), 32'(busy_mask), (c < 6) ? 32'h0008 : 32'h0);
         cyc();
      end
      idle(3);

      // independent reader right behind a vector write
      wr(1, 4'd3);
      cyc();
      rd2(4'd4, 4'd5);
      #2;
      chk("indep_issue", 32'(id_issue), 32'h1);
      chk("indep_stall", 32'(id_stall), 32'h0);
      chk("indep_busy", 32'(busy_mask), 32'h0008);
      idle(7);

      // WAW scalar R7: strict under both settings
      wr(0, 4'd7);
      cyc();
      for (int c = 1; c <= 3; c++) begin
         #2;
         chk($sformatf("waw_issue_c%0d", c), 32'(id_issue), 32'(c == 3));
         chk($sformatf("waw_stall_c%0d", c), 32'(id_stall), 32'(c != 3));
         chk($sformatf("waw_busy_c%0d", c), 32'(busy_mask), (c < 3) ? 32'h0080 : 32'h0);
         cyc();
      end
      clr();
      #2 chk("waw_reload", 32'(busy_mask), 32'h0080);
      idle(4);

      // memory port: back-to-back vector stores, flush in cycle 3
      clr();
      id_valid = 1; id_mem_write = 1; id_is_vector = 1;
      #2 chk("mem_first_issue", 32'(id_issue), 32'h1);
      cyc();
      for (int c = 1; c <= 6; c++) begin
         flush = (c == 3);
         #2;
         chk($sformatf("mem_issue_c%0d", c), 32'(id_issue), 32'(c == 6));
         chk($sformatf("mem_stall_c%0d", c), 32'(id_stall), 32'(c < 6 && c != 3));
         chk($sformatf("mem_busy_c%0d", c), 32'(mem_busy), 32'(c < 6));
         cyc();
      end
      clr();
      #2 chk("mem_second_load", 32'(mem_busy), 32'h1);
      idle(7);

      // both write enables load both trackers
      wr(0, 4'd9);
      id_mem_write = 1;
      #2 chk("both_issue", 32'(id_issue), 32'h1);
      cyc();
      clr();
      #2;
      chk("both_busy", 32'(busy_mask), 32'h0200);
      chk("both_mem", 32'(mem_busy), 32'h1);
      idle(4);

      // asynchronous reset mid-operation
      wr(1, 4'd3);
      cyc();
      clr();
      cyc();
      #2 chk("mid_busy_before", 32'(busy_mask), 32'h0008);
      #1 rst_n = 0;
      #1 chk("mid_busy_rst", 32'(busy_mask), 32'h0);
      #1 rst_n = 1;
      rd2(4'd3, 4'd3);
      #1;
      chk("mid_read_issue", 32'(id_issue), 32'h1);
      chk("mid_read_stall", 32'(id_stall), 32'h0);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
